// File: rtl/tetris_step_scheduler_if.sv
// Operation handshake between the piece scheduler and the playfield datapath.
// The scheduler drives the request side; the playfield answers with ready/ok.
interface tetris_step_scheduler_if;
    logic       op_valid;
    logic [2:0] op_code;
    logic       op_ready;
    logic       op_ok;

    modport master (output op_valid, output op_code, input op_ready, input op_ok);
    modport slave  (input op_valid, input op_code, output op_ready, output op_ok);
endinterface

// File: rtl/tetris_step_scheduler.sv
// Falling-piece lifecycle sequencer: spawn, gravity, player moves, lock,
// line clear and the line/level/score bookkeeping. Move pulses and gravity
// are folded into sticky pending flags and issued one at a time on the op port.
module tetris_step_scheduler #(
    parameter int GRAV_BASE   = 48,
    parameter int GRAV_STEP   = 4,
    parameter int GRAV_MIN    = 2,
    parameter int SOFT_PERIOD = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           frame_tick,
    input  logic                           mv_left,
    input  logic                           mv_right,
    input  logic                           mv_rot,
    input  logic                           soft_drop,
    tetris_step_scheduler_if.master        op,
    output logic                           clr_start,
    input  logic                           clr_done,
    input  logic [2:0]                     clr_lines,
    output logic [15:0]                    lines_total,
    output logic [3:0]                     level,
    output logic                           level_up,
    output logic                           score_inc_valid,
    output logic [7:0]                     score_inc,
    output logic                           over
);

    localparam logic [2:0] OP_LEFT  = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_ROT   = 3'd3;
    localparam logic [2:0] OP_DOWN  = 3'd4;
    localparam logic [2:0] OP_SPAWN = 3'd5;
    localparam logic [2:0] OP_LOCK  = 3'd6;

    typedef enum logic [2:0] {IDLE, SPAWN, FALL, LOCK, CLEAR, OVER} state_t;

    state_t      state_reg;
    logic        op_valid_reg;
    logic [2:0]  op_code_reg;
    logic        clr_start_reg;
    logic        clr_issued_reg;
    logic [15:0] lines_total_reg;
    logic [3:0]  level_reg;
    logic [3:0]  lvl_cnt_reg;
    logic        level_up_reg;
    logic        score_inc_valid_reg;
    logic [7:0]  score_inc_reg;
    logic        over_reg;
    logic [15:0] grav_cnt_reg;
    // Pending flags, index 0=right, 1=left, 2=rotate, 3=down.
    logic [3:0]  pend_reg;
    logic [3:0]  pend_next;
    logic [3:0]  req_vec;

    logic        op_accept;
    logic [31:0] grav_drop;
    logic [15:0] period;
    logic        grav_hit;

    logic [2:0]  clr_n;
    logic [3:0]  clr_pts;
    logic [16:0] lines_sum;
    logic [3:0]  lvl_sum;
    logic [7:0]  score_calc;

    assign op.op_valid       = op_valid_reg;
    assign op.op_code        = op_code_reg;
    assign clr_start         = clr_start_reg;
    assign lines_total       = lines_total_reg;
    assign level             = level_reg;
    assign level_up          = level_up_reg;
    assign score_inc_valid   = score_inc_valid_reg;
    assign score_inc         = score_inc_reg;
    assign over              = over_reg;

    assign op_accept = op_valid_reg & op.op_ready;

    // Gravity period: the level-scaled period is clamped before subtracting,
    // so high levels land on GRAV_MIN instead of wrapping.
    assign grav_drop = 32'(GRAV_STEP) * 32'(level_reg);

    // Select the active gravity period in frames.
    always_comb begin
        if (soft_drop) begin
            period = 16'(SOFT_PERIOD);
        end else if (grav_drop + 32'(GRAV_MIN) >= 32'(GRAV_BASE)) begin
            period = 16'(GRAV_MIN);
        end else begin
            period = 16'(32'(GRAV_BASE) - grav_drop);
        end
    end

    assign grav_hit = frame_tick && (({1'b0, grav_cnt_reg} + 17'd1) >= {1'b0, period});
    assign req_vec  = {grav_hit, mv_rot, mv_left, mv_right};

    // A flag clears only when its own op is accepted; a fresh request in the
    // acceptance cycle re-arms it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pend
            localparam logic [2:0] CODE = (gi == 0) ? OP_RIGHT :
                                          (gi == 1) ? OP_LEFT  :
                                          (gi == 2) ? OP_ROT   : OP_DOWN;
            assign pend_next[gi] = (pend_reg[gi] & ~(op_accept && (op_code_reg == CODE)))
                                   | req_vec[gi];
        end
    endgenerate

    // Line-clear bookkeeping; over-range clr_lines counts as four rows.
    assign clr_n = (clr_lines > 3'd4) ? 3'd4 : clr_lines;

    // Points per clear before the level multiplier.
    always_comb begin
        case (clr_n)
            3'd1:    clr_pts = 4'd1;
            3'd2:    clr_pts = 4'd3;
            3'd3:    clr_pts = 4'd5;
            3'd4:    clr_pts = 4'd8;
            default: clr_pts = 4'd0;
        endcase
    end

    assign lines_sum  = {1'b0, lines_total_reg} + {14'd0, clr_n};
    assign lvl_sum    = lvl_cnt_reg + {1'b0, clr_n};
    assign score_calc = {4'd0, clr_pts} * ({4'd0, level_reg} + 8'd1);

    // Lifecycle FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= IDLE;
            op_valid_reg        <= 1'b0;
            op_code_reg         <= 3'd0;
            clr_start_reg       <= 1'b0;
            clr_issued_reg      <= 1'b0;
            lines_total_reg     <= 16'd0;
            level_reg           <= 4'd0;
            lvl_cnt_reg         <= 4'd0;
            level_up_reg        <= 1'b0;
            score_inc_valid_reg <= 1'b0;
            score_inc_reg       <= 8'd0;
            over_reg            <= 1'b0;
            grav_cnt_reg        <= 16'd0;
            pend_reg            <= 4'd0;
        end else begin
            level_up_reg        <= 1'b0;
            score_inc_valid_reg <= 1'b0;
            clr_start_reg       <= 1'b0;
            case (state_reg)
                IDLE, OVER: begin
                    if (start) begin
                        lines_total_reg <= 16'd0;
                        level_reg       <= 4'd0;
                        lvl_cnt_reg     <= 4'd0;
                        grav_cnt_reg    <= 16'd0;
                        pend_reg        <= 4'd0;
                        over_reg        <= 1'b0;
                        state_reg       <= SPAWN;
                    end
                end
                SPAWN: begin
                    if (!op_valid_reg) begin
                        op_valid_reg <= 1'b1;
                        op_code_reg  <= OP_SPAWN;
                    end else if (op.op_ready) begin
                        op_valid_reg <= 1'b0;
                        if (op.op_ok) begin
                            grav_cnt_reg <= 16'd0;
                            pend_reg     <= 4'd0;
                            state_reg    <= FALL;
                        end else begin
                            over_reg  <= 1'b1;
                            state_reg <= OVER;
                        end
                    end
                end
                FALL: begin
                    pend_reg <= pend_next;
                    if (frame_tick) begin
                        grav_cnt_reg <= grav_hit ? 16'd0 : grav_cnt_reg + 16'd1;
                    end
                    if (op_valid_reg) begin
                        if (op.op_ready) begin
                            op_valid_reg <= 1'b0;
                            if (op_code_reg == OP_DOWN && !op.op_ok) begin
                                pend_reg  <= 4'd0;
                                state_reg <= LOCK;
                            end
                        end
                    end else if (|pend_reg) begin
                        op_valid_reg <= 1'b1;
                        if (pend_reg[3]) begin
                            op_code_reg <= OP_DOWN;
                        end else if (pend_reg[2]) begin
                            op_code_reg <= OP_ROT;
                        end else if (pend_reg[1]) begin
                            op_code_reg <= OP_LEFT;
                        end else begin
                            op_code_reg <= OP_RIGHT;
                        end
                    end
                end
                LOCK: begin
                    if (!op_valid_reg) begin
                        op_valid_reg <= 1'b1;
                        op_code_reg  <= OP_LOCK;
                    end else if (op.op_ready) begin
                        op_valid_reg <= 1'b0;
                        state_reg    <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (!clr_issued_reg) begin
                        clr_start_reg  <= 1'b1;
                        clr_issued_reg <= 1'b1;
                    end else if (clr_done) begin
                        lines_total_reg     <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
                        score_inc_reg       <= score_calc;
                        score_inc_valid_reg <= 1'b1;
                        if (lvl_sum >= 4'd10) begin
                            lvl_cnt_reg <= lvl_sum - 4'd10;
                            if (level_reg != 4'd15) begin
                                level_reg    <= level_reg + 4'd1;
                                level_up_reg <= 1'b1;
                            end
                        end else begin
                            lvl_cnt_reg <= lvl_sum;
                        end
                        clr_issued_reg <= 1'b0;
                        state_reg      <= SPAWN;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_step_scheduler.sv
// Scoreboard bench for tetris_step_scheduler: the driver pushes expected
// events from a behavioural game model, a playfield responder answers the
// handshake, and a monitor pops and compares every DUT event.
module tb_tetris_step_scheduler;

    localparam int GRAV_BASE = 48;
    localparam int GRAV_STEP = 4;
    localparam int GRAV_MIN  = 2;
    localparam int SOFT_P    = 2;

    localparam int EV_OP    = 0;
    localparam int EV_CLR   = 1;
    localparam int EV_SCORE = 2;

    logic        clk = 1'b0;
    logic        rst, start, frame_tick, mv_left, mv_right, mv_rot, soft_drop;
    logic        clr_start, clr_done;
    logic [2:0]  clr_lines;
    logic [15:0] lines_total;
    logic [3:0]  level;
    logic        level_up, score_inc_valid, over;
    logic [7:0]  score_inc;

    tetris_step_scheduler_if op_if();

    tetris_step_scheduler #(
        .GRAV_BASE(GRAV_BASE), .GRAV_STEP(GRAV_STEP),
        .GRAV_MIN(GRAV_MIN), .SOFT_PERIOD(SOFT_P)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
        .mv_left(mv_left), .mv_right(mv_right), .mv_rot(mv_rot),
        .soft_drop(soft_drop), .op(op_if.master),
        .clr_start(clr_start), .clr_done(clr_done), .clr_lines(clr_lines),
        .lines_total(lines_total), .level(level), .level_up(level_up),
        .score_inc_valid(score_inc_valid), .score_inc(score_inc), .over(over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
        int lines;
        int lvl;
        int up;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passes = 0;

    // Game model
    int  m_lines = 0;
    int  m_level = 0;
    int  m_cnt   = 0;
    int  pts[5]  = '{0, 1, 3, 5, 8};

    // Playfield responder controls
    int  fixed_delay = -1;
    bit  down_ok     = 1'b1;
    bit  spawn_ok    = 1'b1;
    int  next_lines  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int period_f();
        int p;
        if (soft_drop) return SOFT_P;
        p = GRAV_BASE - GRAV_STEP * m_level;
        if (p < GRAV_MIN) p = GRAV_MIN;
        return p;
    endfunction

    task automatic push_ev(input int kind, input int val, input int lines, input int lvl, input int up);
        ev_t e;
        e.kind = kind; e.val = val; e.lines = lines; e.lvl = lvl; e.up = up;
        exp_q.push_back(e);
    endtask

    task automatic push_op(input int code);
        push_ev(EV_OP, code, 0, 0, 0);
    endtask

    // Expected consequences of a gravity step under the current ok policy.
    task automatic expect_down();
        int n, old_lvl, new_lvl;
        push_op(4);
        if (!down_ok) begin
            push_op(6);
            push_ev(EV_CLR, 0, 0, 0, 0);
            n = (next_lines > 4) ? 4 : next_lines;
            old_lvl = m_level;
            m_lines = (m_lines + n > 65535) ? 65535 : m_lines + n;
            new_lvl = (m_lines / 10 > 15) ? 15 : m_lines / 10;
            m_level = new_lvl;
            push_ev(EV_SCORE, pts[n] * (old_lvl + 1), m_lines, new_lvl, (new_lvl > old_lvl) ? 1 : 0);
            push_op(5);
            if (spawn_ok) m_cnt = 0;
        end
    endtask

    task automatic do_tick(input bit rt, input bit l, input bit r, output bit hit);
        hit = (m_cnt + 1 >= period_f());
        m_cnt = hit ? 0 : m_cnt + 1;
        if (hit) expect_down();
        if (rt) push_op(3);
        if (l)  push_op(1);
        if (r)  push_op(2);
        frame_tick = 1'b1; mv_rot = rt; mv_left = l; mv_right = r;
        cyc(1);
        frame_tick = 1'b0; mv_rot = 1'b0; mv_left = 1'b0; mv_right = 1'b0;
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            cyc(1);
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        cyc(6);
    endtask

    task automatic gravity_run(input int nticks);
        bit hit;
        for (int i = 0; i < nticks; i++) begin
            do_tick(1'b0, 1'b0, 1'b0, hit);
            if (hit) wait_quiet();
            else cyc($urandom_range(8, 12));
        end
    endtask

    task automatic lock_cycle(input int lines);
        bit hit;
        next_lines = lines;
        down_ok = 1'b0;
        soft_drop = 1'b1;
        hit = 1'b0;
        while (!hit) begin
            do_tick(1'b0, 1'b0, 1'b0, hit);
            cyc(3);
        end
        wait_quiet();
        down_ok = 1'b1;
    endtask

    // Burst of simultaneous requests; optionally a repeat left pulse merges.
    task automatic burst(input bit dn, input bit rt, input bit l, input bit r);
        bit hit;
        soft_drop = 1'b1;
        if (dn) begin
            while (m_cnt + 1 < period_f()) begin
                do_tick(1'b0, 1'b0, 1'b0, hit);
                cyc(2);
            end
            do_tick(rt, l, r, hit);
        end else begin
            if (rt) push_op(3);
            if (l)  push_op(1);
            if (r)  push_op(2);
            mv_rot = rt; mv_left = l; mv_right = r;
            cyc(1);
            mv_rot = 1'b0; mv_left = 1'b0; mv_right = 1'b0;
        end
        if (l && $urandom_range(0, 1) == 1) begin
            mv_left = 1'b1;
            cyc(1);
            mv_left = 1'b0;
        end
        wait_quiet();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_op_valid"}, op_if.op_valid, 0);
        check({tag, "_op_code"}, op_if.op_code, 0);
        check({tag, "_clr_start"}, clr_start, 0);
        check({tag, "_lines_total"}, lines_total, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_level_up"}, level_up, 0);
        check({tag, "_score_valid"}, score_inc_valid, 0);
        check({tag, "_score_inc"}, score_inc, 0);
        check({tag, "_over"}, over, 0);
    endtask

    // Playfield responder: raises ready after a per-op delay, answers ok.
    int resp_wait = 0;
    int resp_delay = 0;
    bit resp_busy = 1'b0;
    initial begin
        op_if.op_ready = 1'b0;
        op_if.op_ok    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || op_if.op_ready) begin
                op_if.op_ready = 1'b0;
                op_if.op_ok    = 1'b0;
                resp_busy      = 1'b0;
            end else if (op_if.op_valid) begin
                if (!resp_busy) begin
                    resp_busy  = 1'b1;
                    resp_wait  = 0;
                    resp_delay = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
                end
                if (resp_wait >= resp_delay) begin
                    op_if.op_ready = 1'b1;
                    case (op_if.op_code)
                        3'd4:    op_if.op_ok = down_ok;
                        3'd5:    op_if.op_ok = spawn_ok;
                        default: op_if.op_ok = 1'($urandom_range(0, 1));
                    endcase
                end else begin
                    resp_wait++;
                end
            end
        end
    end

    // Line-clear responder: answers each clr_start after a short random wait.
    int clr_cd = -1;
    initial begin
        clr_done  = 1'b0;
        clr_lines = 3'd0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                clr_done = 1'b0;
                clr_cd   = -1;
            end else if (clr_done) begin
                clr_done = 1'b0;
            end else begin
                if (clr_start) clr_cd = $urandom_range(0, 4);
                if (clr_cd == 0) begin
                    clr_done  = 1'b1;
                    clr_lines = 3'(next_lines);
                    clr_cd    = -1;
                end else if (clr_cd > 0) begin
                    clr_cd--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every DUT event and checks handshake rules.
    bit         mon_prev_valid = 1'b0;
    bit         mon_prev_acc   = 1'b0;
    logic [2:0] mon_prev_code  = 3'd0;

    task automatic pop_expect(input string name, input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e.kind = -1; e.val = 0; e.lines = 0; e.lvl = 0; e.up = 0;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_%s: got event kind %0d, expected none", name, kind);
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, kind, e.kind);
            ok = (kind == e.kind);
        end
    endtask

    initial begin
        ev_t e;
        bit  ok;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev_valid = 1'b0;
                mon_prev_acc   = 1'b0;
            end else begin
                if (mon_prev_acc) begin
                    check("op_gap", op_if.op_valid, 0);
                end else if (mon_prev_valid) begin
                    check("op_hold_valid", op_if.op_valid, 1);
                    check("op_hold_code", op_if.op_code, mon_prev_code);
                end
                mon_prev_acc   = op_if.op_valid && op_if.op_ready;
                mon_prev_valid = op_if.op_valid;
                mon_prev_code  = op_if.op_code;
                if (mon_prev_acc) begin
                    pop_expect("op", EV_OP, e, ok);
                    if (ok) check("op_code", op_if.op_code, e.val);
                end
                if (clr_start) pop_expect("clr_start", EV_CLR, e, ok);
                if (score_inc_valid) begin
                    pop_expect("score", EV_SCORE, e, ok);
                    if (ok) begin
                        check("score_inc", score_inc, e.val);
                        check("lines_total", lines_total, e.lines);
                        check("level", level, e.lvl);
                        check("level_up", level_up, e.up);
                    end
                end else if (level_up) begin
                    check("level_up_stray", level_up, 0);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit, dn, rt, l, r;
        int k;
        rst = 1'b1; start = 1'b0; frame_tick = 1'b0;
        mv_left = 1'b0; mv_right = 1'b0; mv_rot = 1'b0; soft_drop = 1'b0;
        cyc(3);
        check_all_zero("reset");
        rst = 1'b0;
        cyc(2);

        // Start: spawn request appears two cycles after the start pulse.
        fixed_delay = 3;
        push_op(5);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("spawn_entry_valid", op_if.op_valid, 0);
        cyc(1);
        check("spawn_issue_valid", op_if.op_valid, 1);
        check("spawn_issue_code", op_if.op_code, 5);
        wait_quiet();
        m_cnt = 0;

        // Level-0 gravity, then soft drop.
        fixed_delay = -1;
        soft_drop = 1'b0;
        gravity_run(96);
        soft_drop = 1'b1;
        gravity_run(6);

        // Gravity plus left and right in one cycle with 3-cycle stalls.
        fixed_delay = 3;
        do_tick(1'b0, 1'b0, 1'b0, hit);
        cyc(2);
        do_tick(1'b0, 1'b1, 1'b1, hit);
        check("burst_grav_hit", hit, 1);
        wait_quiet();
        fixed_delay = -1;

        // Randomized move bursts.
        for (int i = 0; i < 12; i++) begin
            dn = 1'($urandom_range(0, 1)); rt = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 1)); r  = 1'($urandom_range(0, 1));
            if (!(dn | rt | l | r)) l = 1'b1;
            burst(dn, rt, l, r);
        end

        // start while falling is ignored.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(8);
        check("start_ignored_over", over, 0);

        // Directed clears: 7 acts as 4, then counter at 8 plus 3 levels up.
        lock_cycle(7);
        lock_cycle(4);
        lock_cycle(3);
        check("level_after_11", level, 1);
        lock_cycle(0);

        // Random clears, probing gravity at levels 11 and 12.
        k = 0;
        while (m_level < 11 && k < 400) begin
            lock_cycle($urandom_range(0, 7));
            k++;
        end
        soft_drop = 1'b0;
        check("period_l11", period_f(), 4);
        gravity_run(12);
        while (m_level < 12 && k < 400) begin
            lock_cycle($urandom_range(0, 7));
            k++;
        end
        soft_drop = 1'b0;
        check("period_l12", period_f(), 2);
        gravity_run(8);
        while (m_level < 15 && k < 400) begin
            lock_cycle($urandom_range(2, 7));
            k++;
        end
        for (int i = 0; i < 3; i++) lock_cycle(4);
        check("level_saturated", level, 15);

        // Spawn failure ends the game; inputs then do nothing.
        spawn_ok = 1'b0;
        lock_cycle(1);
        check("over_set", over, 1);
        for (int i = 0; i < 10; i++) begin
            frame_tick = 1'b1; mv_left = 1'b1; mv_rot = 1'b1; soft_drop = 1'b1;
            cyc(1);
            frame_tick = 1'b0; mv_left = 1'b0; mv_rot = 1'b0;
            cyc(1);
        end
        cyc(6);
        check("over_held", over, 1);
        check("over_no_op", op_if.op_valid, 0);

        // Restart from game over.
        spawn_ok = 1'b1;
        m_lines = 0; m_level = 0; m_cnt = 0;
        push_op(5);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("restart_over", over, 0);
        check("restart_level", level, 0);
        check("restart_lines", lines_total, 0);
        wait_quiet();

        // Reset while a request is stalled.
        fixed_delay = 10;
        mv_rot = 1'b1;
        cyc(1);
        mv_rot = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (op_if.op_valid) break;
            cyc(1);
        end
        check("stall_valid", op_if.op_valid, 1);
        rst = 1'b1;
        cyc(1);
        check_all_zero("midrst");
        rst = 1'b0;
        exp_q.delete();
        fixed_delay = -1;
        cyc(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tetris_step_scheduler.md
# tetris_step_scheduler

Sequences the falling-piece lifecycle for the Tetris core: spawn, gravity, player moves, lock, line clear, scoring and game over. Sits between the debounced key inputs / game automaton and the playfield datapath (`loading_happen` / `square_gen`). It turns asynchronous move pulses and frame-based gravity into one serialized operation stream on a valid/ready port. It also owns the line, level and score-increment bookkeeping.

## Interface
Parameters:
- GRAV_BASE, 48, gravity period in frames at level 0
- GRAV_STEP, 4, frames removed from the period per level
- GRAV_MIN, 2, minimum gravity period in frames
- SOFT_PERIOD, 2, gravity period in frames while soft_drop=1

Ports:
- clk  in  1  system pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse from automaton; begins or restarts a game
- frame_tick  in  1  one-cycle pulse per video frame
- mv_left, mv_right, mv_rot  in  1 each  debounced one-cycle move requests
- soft_drop  in  1  level; selects SOFT_PERIOD
- op_valid  out  1  operation request to playfield
- op_code  out  3  1=left, 2=right, 3=rotate, 4=down, 5=spawn, 6=lock
- op_ready  in  1  playfield accepts op this cycle
- op_ok  in  1  valid with op_ready; 1 = move legal / spawn fits
- clr_start  out  1  one-cycle pulse: scan and remove full rows
- clr_done  in  1  one-cycle pulse: clear finished
- clr_lines  in  3  rows removed, valid with clr_done (values >4 are treated as 4)
- lines_total  out  16  lines cleared this game, saturating
- level  out  4  current level, 0..15
- level_up  out  1  one-cycle pulse on level increment
- score_inc_valid  out  1  one-cycle pulse
- score_inc  out  8  points to add, valid with score_inc_valid
- over  out  1  game over, held

## Operation
- States: IDLE, SPAWN, FALL, LOCK, CLEAR, OVER.
- IDLE or OVER, start=1: zero lines_total, level, level counter and gravity counter; clear over; go to SPAWN. start in any other state is ignored.
- SPAWN: issue op 5. On ok, go to FALL with gravity counter and pending flags cleared. On not-ok, go to OVER with over=1.
- FALL:
  - Move pulses set sticky pending flags; a repeat pulse while its flag is set merges into it.
  - frame_tick increments the gravity counter. When counter+1 >= period, set grav_pending and zero the counter.
  - period = soft_drop ? SOFT_PERIOD : max(GRAV_MIN, GRAV_BASE − GRAV_STEP·level), computed without underflow.
  - Only one op is outstanding at a time. Priority: down > rotate > left > right. The issued op's flag clears on acceptance.
  - Down not-ok: clear all pending flags and go to LOCK. Any other result stays in FALL; a not-ok move is simply dropped.
- LOCK: issue op 6; on acceptance go to CLEAR.
- CLEAR: pulse clr_start once, then wait for clr_done, with no timeout. On clr_done, with n = min(clr_lines, 4):
  - lines_total += n, saturating at 65535.
  - score_inc = {0,1,3,5,8}[n]·(level+1), using the pre-update level. score_inc_valid pulses even when n=0.
  - The level counter (0..9) adds n. At >=10 it subtracts 10 and level increments, saturating at 15; level_up pulses only on an actual increment.
  - Then go to SPAWN.
- Move pulses and frame_tick outside FALL are discarded.

## Timing
- Reset: state IDLE; every output 0; all counters and flags 0. Reset in mid-handshake drops op_valid the next cycle, and the playfield must tolerate this.
- All outputs are registered.
- op_valid rises the cycle after the triggering condition is sampled: state entry, or a pending flag set while no op is outstanding.
- Once op_valid is high, op_valid and op_code are held stable until a cycle with op_ready=1. op_ok is sampled in that same cycle. op_valid is low the next cycle.
- There is at least one op_valid-low cycle between consecutive ops.
- start → op 5 valid 2 cycles later: the SPAWN entry cycle, then the issue cycle.
- clr_start pulses the cycle after CLEAR entry.
- level_up, score_inc_valid and the lines_total update all occur the cycle after clr_done.
- A move pulse arriving in the same cycle as the acceptance of the same op type is kept as a new pending request.

## Test plan
- Reset, then start, with op_ready=op_ok=1: op 5 appears 2 cycles after start. With no keys pressed, op 4 appears exactly once per 48 frame_ticks; soft_drop=1 gives op 4 every 2 frame_ticks.
- Force level 11: period is 4. Force level 12: period clamps to 2 with no wrap.
- Set grav_pending, then pulse mv_left and mv_right in the same cycle, with op_ready delayed 3 cycles on each op: ops are issued in the order 4, 1, 2; op_code stays stable during each stall and op_valid drops between ops.
- op 4 returns ok=0: op 6 follows, then a clr_start pulse. Return clr_done with clr_lines=4 at level 0: score_inc=8, lines_total=4, then op 5.
- Level counter at 8, clear 3 lines at level 0: level=1, level_up pulses once, score_inc=5 (pre-update level). clr_lines=7 behaves identically to 4.
- op 5 returns ok=0: over=1 held, and frame_tick and move pulses produce no ops. A start pulse then gives over=0, level=0, lines_total=0 and a new op 5. Asserting rst while op_valid is high drops every output to 0 the next cycle.
